latch_m: RTL and testbench

EX/MEM pipeline register for the five-stage pipeline. On each rising clock edge it captures the execute-stage control and data results and presents them, held stable for one full cycle, to the memory stage. It contains no logic beyond the storage elements and the reset. The memory write strobe (`mem_write` → `mem_write_reg`) is the primary path; the remaining fields travel in the same register bank.

---
 rtl/latch_m.sv | 58 +++++
 tb/tb_latch_m.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/latch_m.sv
// EX/MEM pipeline register: captures execute-stage control and data on every
// rising clk edge and holds them for the memory stage; rst clears to a NOP.
module latch_m #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic              branch,
  input  logic              zero,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] branch_target,
  input  logic [REG_W-1:0]  write_reg,
  output logic              mem_write_reg,
  output logic              mem_read_reg,
  output logic              reg_write_reg,
  output logic              mem_to_reg_reg,
  output logic              branch_reg,
  output logic              zero_reg,
  output logic [DATA_W-1:0] alu_result_reg,
  output logic [DATA_W-1:0] write_data_reg,
  output logic [DATA_W-1:0] branch_target_reg,
  output logic [REG_W-1:0]  write_reg_reg
);

  // All-zero contents decode as a NOP downstream, so reset needs no special value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_write_reg     <= 1'b0;
      mem_read_reg      <= 1'b0;
      reg_write_reg     <= 1'b0;
      mem_to_reg_reg    <= 1'b0;
      branch_reg        <= 1'b0;
      zero_reg          <= 1'b0;
      alu_result_reg    <= '0;
      write_data_reg    <= '0;
      branch_target_reg <= '0;
      write_reg_reg     <= '0;
    end else begin
      mem_write_reg     <= mem_write;
      mem_read_reg      <= mem_read;
      reg_write_reg     <= reg_write;
      mem_to_reg_reg    <= mem_to_reg;
      branch_reg        <= branch;
      zero_reg          <= zero;
      alu_result_reg    <= alu_result;
      write_data_reg    <= write_data;
      branch_target_reg <= branch_target;
      write_reg_reg     <= write_reg;
    end
  end

endmodule

// File: tb/tb_latch_m.sv
// Bench for latch_m: directed scenarios plus random traffic checked against a
// model where the outputs equal the input bundle seen at the previous edge.
module tb_latch_m;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef struct packed {
    logic              mem_write;
    logic              mem_read;
    logic              reg_write;
    logic              mem_to_reg;
    logic              branch;
    logic              zero;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] branch_target;
    logic [REG_W-1:0]  write_reg;
  } fields_t;

  logic    clk_sys;
  logic    rst;
  fields_t in_v;
  fields_t exp_v;

  logic              mem_write_reg, mem_read_reg, reg_write_reg, mem_to_reg_reg;
  logic              branch_reg, zero_reg;
  logic [DATA_W-1:0] alu_result_reg, write_data_reg, branch_target_reg;
  logic [REG_W-1:0]  write_reg_reg;

  int n_cmp;
  int n_err;

  latch_m #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk               (clk_sys),
    .rst               (rst),
    .mem_write         (in_v.mem_write),
    .mem_read          (in_v.mem_read),
    .reg_write         (in_v.reg_write),
    .mem_to_reg        (in_v.mem_to_reg),
    .branch            (in_v.branch),
    .zero              (in_v.zero),
    .alu_result        (in_v.alu_result),
    .write_data        (in_v.write_data),
    .branch_target     (in_v.branch_target),
    .write_reg         (in_v.write_reg),
    .mem_write_reg     (mem_write_reg),
    .mem_read_reg      (mem_read_reg),
    .reg_write_reg     (reg_write_reg),
    .mem_to_reg_reg    (mem_to_reg_reg),
    .branch_reg        (branch_reg),
    .zero_reg          (zero_reg),
    .alu_result_reg    (alu_result_reg),
    .write_data_reg    (write_data_reg),
    .branch_target_reg (branch_target_reg),
    .write_reg_reg     (write_reg_reg)
  );

  initial clk_sys = 1'b0;
  always #10 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".mem_write"},     64'(mem_write_reg),     64'(exp_v.mem_write));
    chk({tag, ".mem_read"},      64'(mem_read_reg),      64'(exp_v.mem_read));
    chk({tag, ".reg_write"},     64'(reg_write_reg),     64'(exp_v.reg_write));
    chk({tag, ".mem_to_reg"},    64'(mem_to_reg_reg),    64'(exp_v.mem_to_reg));
    chk({tag, ".branch"},        64'(branch_reg),        64'(exp_v.branch));
    chk({tag, ".zero"},          64'(zero_reg),          64'(exp_v.zero));
    chk({tag, ".alu_result"},    64'(alu_result_reg),    64'(exp_v.alu_result));
    chk({tag, ".write_data"},    64'(write_data_reg),    64'(exp_v.write_data));
    chk({tag, ".branch_target"}, 64'(branch_target_reg), 64'(exp_v.branch_target));
    chk({tag, ".write_reg"},     64'(write_reg_reg),     64'(exp_v.write_reg));
  endtask

  // Model: a clean edge makes the outputs a copy of the inputs; reset gives all zero.
  task automatic step();
    @(posedge clk_sys);
    if (!rst) exp_v = in_v;
    #1;
  endtask

  task automatic randomize_inputs();
    in_v.mem_write     = 1'($urandom);
    in_v.mem_read      = 1'($urandom);
    in_v.reg_write     = 1'($urandom);
    in_v.mem_to_reg    = 1'($urandom);
    in_v.branch        = 1'($urandom);
    in_v.zero          = 1'($urandom);
    in_v.alu_result    = $urandom;
    in_v.write_data    = $urandom;
    in_v.branch_target = $urandom;
    in_v.write_reg     = REG_W'($urandom);
  endtask

  initial begin
    int wr_seq[3];
    n_cmp = 0;
    n_err = 0;
    wr_seq[0] = 3;
    wr_seq[1] = 7;
    wr_seq[2] = 12;

    // Reset held with every input at all-ones: edges ignored.
    rst   = 1'b1;
    in_v  = '1;
    exp_v = '0;
    #1;
    check_all("rst_async");
    repeat (3) begin
      step();
      check_all("rst_hold");
    end

    // Basic capture and hold of mem_write.
    @(negedge clk_sys);
    rst  = 1'b0;
    in_v = '0;
    step();
    check_all("rst_release");
    @(negedge clk_sys);
    in_v.mem_write = 1'b1;
    #5;
    chk("pre_edge", 64'(mem_write_reg), 64'd0);
    step();
    chk("capture", 64'(mem_write_reg), 64'd1);
    #2;
    in_v.mem_write = 1'b0;
    @(negedge clk_sys);
    #1;
    chk("hold_negedge", 64'(mem_write_reg), 64'd1);
    step();
    chk("hold_release", 64'(mem_write_reg), 64'd0);

    // Full bank load, then all zero.
    @(negedge clk_sys);
    in_v               = '0;
    in_v.mem_write     = 1'b1;
    in_v.mem_read      = 1'b1;
    in_v.reg_write     = 1'b1;
    in_v.mem_to_reg    = 1'b1;
    in_v.branch        = 1'b1;
    in_v.zero          = 1'b1;
    in_v.alu_result    = 32'h0000_0010;
    in_v.write_data    = 32'h1234_5678;
    in_v.branch_target = 32'h0040_0020;
    in_v.write_reg     = 5'd31;
    step();
    check_all("full_bank");
    @(negedge clk_sys);
    in_v = '0;
    step();
    check_all("full_zero");

    // Back-to-back destination register indices.
    foreach (wr_seq[i]) begin
      @(negedge clk_sys);
      in_v.write_reg = REG_W'(wr_seq[i]);
      step();
      chk("b2b_write_reg", 64'(write_reg_reg), 64'(wr_seq[i]));
    end

    // Async reset between edges.
    @(negedge clk_sys);
    in_v.mem_write  = 1'b1;
    in_v.alu_result = 32'hDEAD_BEEF;
    step();
    chk("pre_rst_mem_write", 64'(mem_write_reg), 64'd1);
    chk("pre_rst_alu", 64'(alu_result_reg), 64'hDEAD_BEEF);
    #4;
    rst = 1'b1;
    #1;
    exp_v = '0;
    check_all("mid_rst");
    step();
    check_all("mid_rst_edge");
    @(negedge clk_sys);
    rst = 1'b0;

    // Random traffic with occasional mid-cycle reset pulses.
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_sys);
      randomize_inputs();
      step();
      check_all("rand");
      if ($urandom_range(0, 19) == 0) begin
        #3;
        rst = 1'b1;
        #1;
        exp_v = '0;
        check_all("rand_rst");
        @(negedge clk_sys);
        rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
